// File: rtl/snn_pkg.sv
// Shared defaults and event-word layout for the spike event logger.
// An event word is {lost, timestamp}.
package snn_pkg;
   localparam int unsigned TS_W     = 7;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned LOST_BIT = TS_W;
   localparam int unsigned EVT_W    = TS_W + 1;
endpackage

// File: rtl/spike_fifo.sv
// Generic synchronous FIFO with registered storage and a level count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module spike_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_LVL);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign level   = count;
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // Pointers are power-of-2 wide, so they wrap modulo DEPTH naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/spike_event_logger.sv
// Timestamps rising edges of a neuron spike line and queues them on a
// valid/ready stream; tracks a saturating spike count and a lost-event flag.
module spike_event_logger #(
   parameter int unsigned TS_W  = snn_pkg::TS_W,
   parameter int unsigned DEPTH = snn_pkg::DEPTH,
   parameter int unsigned CNT_W = snn_pkg::CNT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     spike_i,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [TS_W:0]            evt_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         spike_total
);
   logic [TS_W-1:0] ts;
   logic            spike_q;
   logic            lost_pending;
   logic            spike_evt;
   logic            pop;
   logic            dropped;
   logic            fifo_full;
   logic            fifo_empty;

   assign spike_evt = spike_i & ~spike_q & enable;
   assign evt_valid = ~fifo_empty;
   assign pop       = evt_valid & evt_ready;
   assign dropped   = spike_evt & fifo_full & ~pop;

   spike_fifo #(
      .WIDTH (TS_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (spike_evt),
      .pop   (pop),
      .wdata ({lost_pending, ts}),
      .rdata (evt_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts           <= '0;
         spike_q      <= 1'b0;
         lost_pending <= 1'b0;
         spike_total  <= '0;
      end else begin
         spike_q <= spike_i;
         if (enable) ts <= ts + 1'b1;
         // Every drop re-sets the flag; the next accepted write consumes it.
         if (dropped)        lost_pending <= 1'b1;
         else if (spike_evt) lost_pending <= 1'b0;
         if (spike_evt && spike_total != '1) spike_total <= spike_total + 1'b1;
      end
   end
endmodule

// File: tb/tb_spike_event_logger.sv
// Directed self-checking bench for spike_event_logger with default parameters.
module tb_spike_event_logger;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       spike_i = 1'b0;
   logic       evt_ready = 1'b0;
   logic       evt_valid;
   logic [7:0] evt_data;
   logic [2:0] level;
   logic [7:0] spike_total;

   int unsigned total = 0;
   int unsigned bad = 0;
   logic [6:0]  ts_m = '0;
   logic [6:0]  t_hold;

   spike_event_logger dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .spike_i     (spike_i),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_data    (evt_data),
      .level       (level),
      .spike_total (spike_total)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; the bench's timestamp model follows the rising edge.
   task automatic step();
      @(posedge clk);
      if (rst) ts_m = '0;
      else if (enable) ts_m = ts_m + 7'd1;
      #1;
   endtask

   task automatic pulse();
      spike_i = 1'b1;
      step();
      spike_i = 1'b0;
      step();
   endtask

   task automatic wait_ts(input logic [6:0] target);
      int unsigned n = 0;
      while (ts_m != target && n < 300) begin
         step();
         n++;
      end
      if (ts_m != target) check("wait_ts_timeout", 32'(ts_m), 32'(target));
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_data", 32'(evt_data), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_total", 32'(spike_total), 32'd0);

      // Single spike at ts=5, one-cycle latency
      enable = 1'b1;
      wait_ts(7'd5);
      spike_i = 1'b1;
      check("no_bypass", 32'(evt_valid), 32'd0);
      step();
      spike_i = 1'b0;
      check("t1_valid", 32'(evt_valid), 32'd1);
      check("t1_data", 32'(evt_data), 32'h05);
      check("t1_level", 32'(level), 32'd1);
      check("t1_total", 32'(spike_total), 32'd1);
      evt_ready = 1'b1;
      step();
      check("t1_popped", 32'(evt_valid), 32'd0);
      step();
      check("ready_empty_ignored", 32'(level), 32'd0);
      evt_ready = 1'b0;

      // Long spike is one event; re-enable while high gives none
      spike_i = 1'b1;
      t_hold = ts_m;
      repeat (10) step();
      check("hold_level", 32'(level), 32'd1);
      check("hold_total", 32'(spike_total), 32'd2);
      check("hold_data", 32'(evt_data), 32'({1'b0, t_hold}));
      enable = 1'b0;
      step();
      enable = 1'b1;
      repeat (3) step();
      check("reenable_level", 32'(level), 32'd1);
      check("reenable_total", 32'(spike_total), 32'd2);
      spike_i = 1'b0;
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      check("hold_drained", 32'(level), 32'd0);

      // Overflow: six spikes into a depth-4 FIFO
      wait_ts(7'd10);
      repeat (6) pulse();
      check("ovf_level", 32'(level), 32'd4);
      check("ovf_total", 32'(spike_total), 32'd8);
      check("ovf_head", 32'(evt_data), 32'h0A);
      step();
      check("stall_stable", 32'(evt_data), 32'h0A);
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      check("ovf_pop_level", 32'(level), 32'd3);
      wait_ts(7'd30);
      pulse();
      check("lost_level", 32'(level), 32'd4);
      check("lost_total", 32'(spike_total), 32'd9);
      evt_ready = 1'b1;
      check("drain0", 32'(evt_data), 32'h0C);
      step();
      check("drain1", 32'(evt_data), 32'h0E);
      step();
      check("drain2", 32'(evt_data), 32'h10);
      step();
      check("drain_lost", 32'(evt_data), 32'h9E);
      step();
      evt_ready = 1'b0;
      check("drain_empty", 32'(evt_valid), 32'd0);

      // Full FIFO: simultaneous pop and push
      wait_ts(7'd40);
      repeat (4) pulse();
      check("full_level", 32'(level), 32'd4);
      spike_i = 1'b1;
      evt_ready = 1'b1;
      step();
      spike_i = 1'b0;
      evt_ready = 1'b0;
      check("pp_level", 32'(level), 32'd4);
      check("pp_total", 32'(spike_total), 32'd14);
      check("pp_head", 32'(evt_data), 32'h2A);
      // Drain with enable low
      enable = 1'b0;
      evt_ready = 1'b1;
      step();
      check("pp_d1", 32'(evt_data), 32'h2C);
      step();
      check("pp_d2", 32'(evt_data), 32'h2E);
      step();
      check("pp_tail", 32'(evt_data), 32'h30);
      step();
      check("pp_empty", 32'(level), 32'd0);
      evt_ready = 1'b0;

      // Timestamp wrap 127 -> 0
      enable = 1'b1;
      wait_ts(7'd127);
      spike_i = 1'b1;
      step();
      spike_i = 1'b0;
      enable = 1'b0;
      step();
      enable = 1'b1;
      spike_i = 1'b1;
      step();
      spike_i = 1'b0;
      check("wrap_level", 32'(level), 32'd2);
      check("wrap_first", 32'(evt_data), 32'h7F);
      evt_ready = 1'b1;
      step();
      check("wrap_second", 32'(evt_data), 32'h00);
      step();
      evt_ready = 1'b0;
      check("wrap_total", 32'(spike_total), 32'd16);

      // Build up total=200 with a full FIFO and a pending lost flag, then reset
      evt_ready = 1'b1;
      repeat (179) pulse();
      evt_ready = 1'b0;
      check("pre5_level", 32'(level), 32'd0);
      repeat (5) pulse();
      check("pre_total", 32'(spike_total), 32'd200);
      check("pre_level", 32'(level), 32'd4);
      check("pre_lost", 32'(dut.lost_pending), 32'd1);
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(evt_valid), 32'd0);
      check("arst_level", 32'(level), 32'd0);
      check("arst_total", 32'(spike_total), 32'd0);
      check("arst_lost", 32'(dut.lost_pending), 32'd0);
      check("arst_data", 32'(evt_data), 32'd0);
      step();
      rst = 1'b0;

      // Saturation
      repeat (254) pulse();
      check("sat_254", 32'(spike_total), 32'd254);
      repeat (46) pulse();
      check("sat_255", 32'(spike_total), 32'd255);
      check("sat_level", 32'(level), 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
